// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port of the multicycle RV32I core between
//   instruction fetch (IF) and data load/store (D). Fixed priority D over IF,
//   except that IF is forced to win once D has been granted STARVE_MAX times in
//   a row while IF was waiting. One access is in flight at a time; every
//   memory-side output and every requester response is registered.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a BUSY cycle counter aborts an access after TIMEOUT cycles
//     without mem_ack_i. The owner is acked with rdata = 0 and its error flag
//     (if_err_o / d_err_o) pulses with the ack. When undefined, the err ports
//     do not exist and a BUSY state waits for mem_ack_i indefinitely.
//
//   Ports
//     clk_i, rstn_i              clock (rising edge), async active-low reset
//     if_req_i, if_addr_i        fetch request / address (req held until ack)
//     if_ack_o, if_rdata_o       fetch done pulse, instruction (held to next ack)
//     d_req_i, d_we_i, d_addr_i  data request, store select, address
//     d_wdata_i, d_be_i          store data and byte enables
//     d_ack_o, d_rdata_o         data done pulse, load data (stores keep it)
//     mem_req_o .. mem_be_o      registered memory request, held until ack
//     mem_rdata_i, mem_ack_i     memory read data, one-cycle completion pulse
//     grant_o                    current owner: 00 none, 01 IF, 10 D
//     if_err_o, d_err_o          timeout flags (ARB_TIMEOUT_EN only)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | arbitrate between if_req_i and d_req_i every cycle
//   BUSY_IF | fetch access on the memory port, waiting for mem_ack_i
//   BUSY_D  | load/store access on the memory port, waiting for mem_ack_i
//   RESP    | owner's ack is high; requests ignored; grant clears on exit

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,

  output logic [1:0]          grant_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                if_err_o,
  output logic                d_err_o
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  if (STARVE_MAX < 1 || TIMEOUT < 2) begin : g_param_check
    $error("mem_port_arbiter: STARVE_MAX must be >= 1 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [SW-1:0]     starve_q,    starve_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;
  logic              if_ack_q,    if_ack_d;
  logic              d_ack_q,     d_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic [1:0]        grant_q,     grant_d;
`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0]     tmr_q,       tmr_d;
  logic              if_err_q,    if_err_d;
  logic              d_err_q,     d_err_d;
`endif

  logic d_wins;
  logic starved;

  // IF is starved only when it is actually waiting and the streak is full.
  assign starved = if_req_i && (starve_q == STARVE_LIM);
  assign d_wins  = d_req_i && !starved;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = grant_q;
`ifdef ARB_TIMEOUT_EN
    tmr_d       = tmr_q;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          mem_be_d    = d_be_i;
          grant_d     = GNT_D;
          if (!if_req_i) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          tmr_d = TW'(TIMEOUT - 1);
`endif
        end else if (if_req_i) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          mem_be_d   = '1;
          grant_d    = GNT_IF;
          starve_d   = '0;
`ifdef ARB_TIMEOUT_EN
          tmr_d = TW'(TIMEOUT - 1);
`endif
        end else begin
          starve_d = '0;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end
        end
`ifdef ARB_TIMEOUT_EN
        // tmr_q == 0 means this is the TIMEOUT-th BUSY cycle with no ack.
        else if (tmr_q == '0) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end

      RESP: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      grant_q     <= GNT_NONE;
`ifdef ARB_TIMEOUT_EN
      tmr_q       <= '0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      grant_q     <= grant_d;
`ifdef ARB_TIMEOUT_EN
      tmr_q       <= tmr_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
`endif
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign grant_o     = grant_q;
`ifdef ARB_TIMEOUT_EN
  assign if_err_o    = if_err_q;
  assign d_err_o     = d_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 ns after a rising
//   edge and outputs are sampled at the same point, so every check sees the
//   registers that the preceding edge loaded. The timeout scenario is built
//   only when ARB_TIMEOUT_EN is defined.

module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [1:0]  grant_o;
`ifdef ARB_TIMEOUT_EN
  logic        if_err_o;
  logic        d_err_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_be_i      (d_be_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .grant_o     (grant_o)
`ifdef ARB_TIMEOUT_EN
    ,
    .if_err_o    (if_err_o),
    .d_err_o     (d_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0;  if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0;   d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;

    // Reset state
    tick();
    check("rst mem_req", mem_req_o, 0);
    check("rst grant", grant_o, 0);
    check("rst acks", {if_ack_o, d_ack_o}, 0);
    check("rst mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 0);
    check("rst rdata", {if_rdata_o, d_rdata_o}, 0);
    rstn_i = 1'b1;
    tick();

    // Single fetch, memory acks in the second BUSY cycle
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    check("f1 mem_req", mem_req_o, 1);
    check("f1 mem_addr", mem_addr_o, 32'h100);
    check("f1 we/be", {mem_we_o, mem_be_o}, 5'h0F);
    check("f1 grant", grant_o, 2'b01);
    check("f1 no ack yet", if_ack_o, 0);
    tick();
    check("f1 mem_req held", mem_req_o, 1);
    check("f1 no ack busy", if_ack_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00500093;
    tick();
    check("f1 if_ack", if_ack_o, 1);
    check("f1 if_rdata", if_rdata_o, 32'h00500093);
    check("f1 mem_req drop", mem_req_o, 0);
    check("f1 grant in resp", grant_o, 2'b01);
    mem_ack_i = 1'b0; mem_rdata_i = '0; if_req_i = 1'b0;
    tick();
    check("f1 ack pulse end", if_ack_o, 0);
    check("f1 grant none", grant_o, 2'b00);
    check("f1 rdata held", if_rdata_o, 32'h00500093);

    // Simultaneous requests: D first, then IF
    if_req_i = 1'b1; if_addr_i = 32'h104;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000; d_be_i = 4'hF;
    tick();
    check("sim grant D", grant_o, 2'b10);
    check("sim mem_addr D", mem_addr_o, 32'h2000);
    check("sim mem_we D", mem_we_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11223344;
    tick();
    check("sim d_ack", d_ack_o, 1);
    check("sim d_rdata", d_rdata_o, 32'h11223344);
    check("sim no if_ack", if_ack_o, 0);
    mem_ack_i = 1'b0; d_req_i = 1'b0;
    tick();
    check("sim d_ack once", d_ack_o, 0);
    check("sim idle grant", grant_o, 2'b00);
    tick();
    check("sim grant IF", grant_o, 2'b01);
    check("sim mem_addr IF", mem_addr_o, 32'h104);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00A00113;
    tick();
    check("sim if_ack", {if_ack_o, d_ack_o}, 2'b10);
    check("sim if_rdata", if_rdata_o, 32'h00A00113);
    mem_ack_i = 1'b0; if_req_i = 1'b0;
    tick();
    check("sim if_ack once", if_ack_o, 0);

    // Store keeps d_rdata; requester inputs changing while busy are ignored
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h3004; d_wdata_i = 32'hCAFEBABE; d_be_i = 4'h3;
    tick();
    check("st grant", grant_o, 2'b10);
    check("st we/be", {mem_we_o, mem_be_o}, 5'h13);
    check("st addr", mem_addr_o, 32'h3004);
    check("st wdata", mem_wdata_o, 32'hCAFEBABE);
    d_addr_i = 32'hFFFF0000; d_we_i = 1'b0; d_be_i = 4'hF; d_wdata_i = 32'h0;
    tick();
    check("st latched", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, 4'h3, 32'h3004, 32'hCAFEBABE});
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADDEAD;
    tick();
    check("st d_ack", d_ack_o, 1);
    check("st d_rdata kept", d_rdata_o, 32'h11223344);
    mem_ack_i = 1'b0; d_req_i = 1'b0;
    tick();

    // Starvation: D held, IF waiting; IF wins every 5th grant
    if_req_i = 1'b1; if_addr_i = 32'h200;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400; d_be_i = 4'hF;
    for (int k = 0; k < 10; k++) begin
      logic [1:0] exp_g;
      exp_g = (k == 4 || k == 9) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("starve grant %0d", k), grant_o, exp_g);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5000 + 32'(k);
      tick();
      check($sformatf("starve ack %0d", k), {if_ack_o, d_ack_o},
            (exp_g == 2'b01) ? 2'b10 : 2'b01);
      mem_ack_i = 1'b0;
      tick();
    end
    check("starve if_rdata", if_rdata_o, 32'h5009);
    check("starve d_rdata", d_rdata_o, 32'h5008);
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // Stray mem_ack in IDLE is ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    tick();
    check("stray acks", {if_ack_o, d_ack_o}, 0);
    check("stray state", {mem_req_o, grant_o}, 0);
    mem_ack_i = 1'b0;
    tick();
    check("stray rdata kept", if_rdata_o, 32'h5009);

    // Reset in BUSY_D before mem_ack
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600;
    tick();
    check("rmid busy", {mem_req_o, grant_o}, 3'b110);
    #2 rstn_i = 1'b0;
    #1;
    check("rmid async clear", {mem_req_o, grant_o, if_ack_o, d_ack_o}, 0);
    d_req_i = 1'b0;
    tick();
    check("rmid no ack", d_ack_o, 0);
    rstn_i = 1'b1;
    tick();
    check("rmid idle", {mem_req_o, grant_o, d_ack_o}, 0);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    check("rmid fetch grant", grant_o, 2'b01);
    check("rmid fetch addr", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    check("rmid fetch ack", {if_ack_o, d_ack_o}, 2'b10);
    check("rmid fetch rdata", if_rdata_o, 32'h12345678);
    mem_ack_i = 1'b0; if_req_i = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Memory never acks a fetch; abort after 16 BUSY cycles
    if_req_i = 1'b1; if_addr_i = 32'h500;
    tick();
    check("to grant", grant_o, 2'b01);
    repeat (15) tick();
    check("to still busy", {mem_req_o, if_ack_o, if_err_o}, 3'b100);
    tick();
    check("to ack/err", {if_ack_o, if_err_o, d_ack_o, d_err_o}, 4'b1100);
    check("to rdata zero", if_rdata_o, 0);
    check("to mem_req drop", mem_req_o, 0);
    if_req_i = 1'b0;
    tick();
    check("to err pulse", {if_ack_o, if_err_o}, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
    tick();
    check("to late ack ignored", {if_ack_o, d_ack_o, if_rdata_o}, 0);
    mem_ack_i = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RV32I core between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the control/datapath and the memory model.
- Serialises accesses with a request/ack handshake and arbitrates fixed-priority (D over IF), with anti-starvation for IF.
- Registers all memory-side outputs and all requester responses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
STARVE_MAX, 4, consecutive D grants while IF waits before IF is forced to win
TIMEOUT, 16, cycles to wait for mem_ack (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetched instruction, valid with if_ack and held until next IF ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid with d_ack
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle memory completion pulse
grant  out  2  current owner: 00 none, 01 IF, 10 D
if_err, d_err  out  1  timeout error flags; present only with ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; starvation counter = 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, if_rdata, d_rdata, grant, and err flags.
  - An in-flight transaction is dropped, with no ack; requesters reissue after reset.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE, arbitration each cycle:
  - D wins if d_req=1, unless starve_cnt==STARVE_MAX and if_req=1; then IF wins.
  - Otherwise IF wins if if_req=1.
  - On a win: latch the winner's addr/wdata/be/we into the mem_* registers, set mem_req=1, set grant, go to BUSY_x. mem_req is therefore high the cycle after the req is sampled.
  - IF access is forced to mem_we=0, mem_be=all ones.
- Starvation counter:
  - D granted while if_req=1: +1, saturating at STARVE_MAX.
  - IF granted, or if_req=0 at an arbitration: cleared to 0.
- BUSY_x:
  - mem_* held stable until mem_ack=1.
  - On mem_ack: mem_req=0; mem_rdata captured into if_rdata (IF) or d_rdata (D load); assert the owner's ack for exactly one cycle; go to RESP.
  - Store acks leave d_rdata unchanged.
  - Latency: requester ack is 1 cycle after mem_ack; minimum req-to-ack is 3 cycles with a zero-wait memory.
- RESP:
  - Ack is high this cycle; grant returns to 00; go to IDLE.
  - The requester drops or changes req on the cycle after ack; the arbiter ignores requests in RESP.
  - Back-to-back grants are therefore separated by at least one IDLE cycle.
- Error cases:
  - mem_ack in IDLE or RESP is ignored.
  - Requester inputs changing while busy are ignored because the mem_* values are latched.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY_x.
  - If TIMEOUT cycles pass without mem_ack: drop mem_req, ack the owner with rdata=0, pulse the owner's err flag with the ack, go to RESP.
  - A late mem_ack after timeout is ignored.
- Undefined: no counter and no err ports; BUSY_x waits indefinitely.

Test Plan:
- Single fetch: if_req, if_addr=0x100; memory acks after 2 cycles with 0x00500093 -> mem_req rises cycle+1 with mem_addr=0x100, mem_we=0, mem_be=0xF; if_ack one-cycle pulse 1 cycle after mem_ack; if_rdata=0x00500093; grant 01→00.
- Simultaneous req: if_req and d_req (load 0x2000) in the same IDLE cycle -> D served first (grant=10), then IF; d_rdata=mem data; exactly one ack per requester.
- Starvation: d_req held continuously (reissued after each ack) with if_req high -> after 4 D grants the 5th grant goes to IF; counter then clears.
- Store: d_we=1, d_addr=0x3004, d_wdata=0xCAFEBABE, d_be=0x3 -> mem_we=1 and mem_be=0x3 carry those values; d_ack pulses; d_rdata unchanged from the previous load.
- Reset mid-op: rstn low while in BUSY_D before mem_ack -> mem_req, grant, and acks go 0 immediately with no ack issued; after release, a new if_req is served normally.
- ARB_TIMEOUT_EN: memory never acks a fetch -> after 16 BUSY cycles if_ack=1, if_err=1, if_rdata=0; a later stray mem_ack produces no ack.
